// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/sub controller.
package nibble_serial_addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_nibble_slice.sv
// Combinational 4-bit ripple adder; b arrives pre-inverted for subtract.
// c3 (carry into the top bit) feeds signed-overflow detection.
module addsub_nibble_slice
  import nibble_serial_addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[NIBBLE_W];
  assign c3   = c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_addsub.sv
// N-bit add/sub sequenced over one 4-bit slice, LSB nibble first.
// Optional signed-overflow output enabled by defining ADDSUB_OVF_EN.
//
// state | meaning
// IDLE  | ready for an operation (in_ready=1)
// RUN   | one nibble per cycle through the slice, carry registered
// DONE  | result/cout/ovf held, out_valid=1 until out_ready
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t              state, state_nx;
  logic [IDX_W-1:0]    idx;
  logic [WIDTH-1:0]    a_q, b_q, result_q;
  logic                sub_q, carry_q, cout_q;
  logic [NIBBLE_W-1:0] a_nib, b_nib, sum_nib;
  logic                slice_cout, slice_c3;
  logic                last;

  assign last = (idx == LAST_IDX);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last)     state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs decode the state register only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // operand nibble select; b is inverted here so the slice stays a plain adder
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
      end
    end
  end

  addsub_nibble_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

`ifdef ADDSUB_OVF_EN
  logic ovf_q;
`else
  logic unused_c3;
  assign unused_c3 = slice_c3;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            sub_q    <= sub;
            carry_q  <= sub;
            idx      <= '0;
            result_q <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IDX_W'(i)) result_q[i*NIBBLE_W +: NIBBLE_W] <= sum_nib;
          end
          carry_q <= slice_cout;
          if (last) begin
            idx    <= '0;
            cout_q <= slice_cout;
`ifdef ADDSUB_OVF_EN
            ovf_q  <= slice_c3 ^ slice_cout;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
`ifdef ADDSUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed self-checking bench for nibble_serial_addsub (WIDTH=16).
// Overflow checks run only when ADDSUB_OVF_EN is defined.
module tb_nibble_serial_addsub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
`ifdef ADDSUB_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_addsub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout)
`ifdef ADDSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_ovf();
`ifdef ADDSUB_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one operation and wait (bounded) for out_valid; lat=-1 on timeout.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tsub,
                        output logic [15:0] res, output logic co, output logic ov,
                        output int lat);
    int k;
    lat = -1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    a = ta; b = tb_; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    res = result; co = cout; ov = get_ovf();
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 ||
        cout !== 1'b0 || get_ovf() !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=%h cout=%b ovf=%b, want 1 0 0000 0 0",
               in_ready, out_valid, result, cout, get_ovf());
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [15:0] r; logic co, ov; int lat;
    run_op(16'h1234, 16'h0FFF, 1'b0, r, co, ov, lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL add_latency: got %0d want 4", lat);
    end
    n_checks++;
    if (r !== 16'h2233 || co !== 1'b0 || ov !== 1'b0) begin
      n_fail++; $display("FAIL add_1234_0fff: got %h c=%b v=%b want 2233 c=0 v=0", r, co, ov);
    end
    release_out();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] r; logic co, ov; int lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, r, co, ov, lat);
    n_checks++;
    if (lat !== 4 || r !== 16'h0000 || co !== 1'b1 || ov !== 1'b0) begin
      n_fail++; $display("FAIL wrap: lat=%0d got %h c=%b v=%b want 4 0000 c=1 v=0", lat, r, co, ov);
    end
    release_out();
  endtask

  task automatic test_sub();
    logic [15:0] r; logic co, ov; int lat;
    run_op(16'h0005, 16'h0007, 1'b1, r, co, ov, lat);
    n_checks++;
    if (lat !== 4 || r !== 16'hFFFE || co !== 1'b0 || ov !== 1'b0) begin
      n_fail++; $display("FAIL sub_borrow: lat=%0d got %h c=%b v=%b want 4 fffe c=0 v=0", lat, r, co, ov);
    end
    release_out();
    run_op(16'h0007, 16'h0005, 1'b1, r, co, ov, lat);
    n_checks++;
    if (lat !== 4 || r !== 16'h0002 || co !== 1'b1 || ov !== 1'b0) begin
      n_fail++; $display("FAIL sub_noborrow: lat=%0d got %h c=%b v=%b want 4 0002 c=1 v=0", lat, r, co, ov);
    end
    release_out();
  endtask

`ifdef ADDSUB_OVF_EN
  task automatic test_ovf();
    logic [15:0] r; logic co, ov; int lat;
    run_op(16'h7FFF, 16'h0001, 1'b0, r, co, ov, lat);
    n_checks++;
    if (lat !== 4 || r !== 16'h8000 || co !== 1'b0 || ov !== 1'b1) begin
      n_fail++; $display("FAIL ovf_add: lat=%0d got %h c=%b v=%b want 4 8000 c=0 v=1", lat, r, co, ov);
    end
    release_out();
    run_op(16'h8000, 16'h0001, 1'b1, r, co, ov, lat);
    n_checks++;
    if (lat !== 4 || r !== 16'h7FFF || co !== 1'b1 || ov !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sub: lat=%0d got %h c=%b v=%b want 4 7fff c=1 v=1", lat, r, co, ov);
    end
    release_out();
  endtask
`endif

  // Hold DONE with a pending request; the new op must start only from IDLE.
  task automatic test_backpressure();
    logic [15:0] r; logic co, ov; int lat;
    run_op(16'h1234, 16'h0FFF, 1'b0, r, co, ov, lat);
    a = 16'h0007; b = 16'h0005; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h2233 || cout !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b result=%h cout=%b want 1 0 2233 0",
                 i, out_valid, in_ready, result, cout);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_idle: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_accept: in_ready=%b want 0", in_ready);
    end
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = c; break; end
    end
    n_checks++;
    if (lat !== 4 || result !== 16'h0002 || cout !== 1'b1) begin
      n_fail++; $display("FAIL bp_next_op: lat=%0d result=%h cout=%b want 4 0002 1", lat, result, cout);
    end
    release_out();
  endtask

  task automatic test_early_ready();
    logic [15:0] r; logic co, ov; int lat;
    out_ready = 1'b1;
    run_op(16'h00F0, 16'h0F10, 1'b0, r, co, ov, lat);
    n_checks++;
    if (lat !== 4 || r !== 16'h1000 || co !== 1'b0) begin
      n_fail++; $display("FAIL early_ready: lat=%0d got %h c=%b want 4 1000 c=0", lat, r, co);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL early_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] r; logic co, ov; int lat;
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mid_run: in_ready=%b out_valid=%b result=%h want 1 0 0000",
                         in_ready, out_valid, result);
    end
    run_op(16'h0001, 16'h0001, 1'b0, r, co, ov, lat);
    n_checks++;
    if (lat !== 4 || r !== 16'h0002 || co !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_op: lat=%0d got %h c=%b want 4 0002 c=0", lat, r, co);
    end
    release_out();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    test_reset();
    test_add();
    test_wrap();
    test_sub();
`ifdef ADDSUB_OVF_EN
    test_ovf();
`endif
    test_backpressure();
    test_early_ready();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
